// File: rtl/segre_mem_stage.sv
// segre MEM stage: performs the data-memory access for the EX/MEM bundle over a
// req/gnt/rvalid handshake and hands a registered writeback bundle to WB.
package segre_pkg;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} memop_data_type_e;
endpackage

module segre_mem_stage
  import segre_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int REG_SIZE  = 5
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 valid_i,
  input  logic [WORD_SIZE-1:0] alu_res_i,
  input  logic                 rf_we_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_i,
  input  logic [WORD_SIZE-1:0] rf_st_data_i,
  input  memop_data_type_e     memop_type_i,
  input  logic                 memop_rd_i,
  input  logic                 memop_wr_i,
  input  logic                 memop_sign_ext_i,
  input  logic                 tkbr_i,
  input  logic [ADDR_SIZE-1:0] new_pc_i,
  input  logic [ADDR_SIZE-1:0] seq_new_pc_i,
  input  logic                 is_jaljalr_i,
  output logic                 stall_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [ADDR_SIZE-1:0] dmem_addr_o,
  output logic [3:0]           dmem_be_o,
  output logic [WORD_SIZE-1:0] dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [WORD_SIZE-1:0] dmem_rdata_i,
  output logic                 wb_valid_o,
  output logic                 rf_we_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_wdata_o,
  output logic                 misaligned_o,
  output logic                 tkbr_o,
  output logic [ADDR_SIZE-1:0] new_pc_o
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  function automatic logic is_misaligned(input memop_data_type_e t, input logic [1:0] off);
    case (t)
      BYTE:    return 1'b0;
      HALF:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input memop_data_type_e t, input logic [1:0] off);
    case (t)
      BYTE:    return 4'b0001 << off;
      HALF:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [WORD_SIZE-1:0] lane_replicate(input memop_data_type_e t,
                                                          input logic [WORD_SIZE-1:0] d);
    case (t)
      BYTE:    return WORD_SIZE'({4{d[7:0]}});
      HALF:    return WORD_SIZE'({2{d[15:0]}});
      default: return d;
    endcase
  endfunction

  function automatic logic [WORD_SIZE-1:0] load_extract(input logic [WORD_SIZE-1:0] rdata,
                                                        input logic [1:0] off,
                                                        input memop_data_type_e t,
                                                        input logic sext);
    logic [WORD_SIZE-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (t)
      BYTE:    return {{(WORD_SIZE-8){sext & sh[7]}}, sh[7:0]};
      HALF:    return {{(WORD_SIZE-16){sext & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  state_e                 r_state, w_next;
  logic [ADDR_SIZE-1:0]   r_addr;
  memop_data_type_e       r_type;
  logic                   r_sext, r_we, r_wr;
  logic [REG_SIZE-1:0]    r_waddr;
  logic [3:0]             r_be;
  logic [WORD_SIZE-1:0]   r_wdata;
  logic                   r_wb_valid, r_rf_we, r_mis, r_tkbr;
  logic [REG_SIZE-1:0]    r_rf_waddr;
  logic [WORD_SIZE-1:0]   r_rf_wdata;
  logic [ADDR_SIZE-1:0]   r_new_pc;
  logic [ADDR_SIZE-1:0]   w_addr;
  logic                   w_memop, w_mis, w_start_mem;

  assign w_addr      = ADDR_SIZE'(alu_res_i);
  assign w_memop     = memop_rd_i | memop_wr_i;
  assign w_mis       = w_memop & is_misaligned(memop_type_i, w_addr[1:0]);
  assign w_start_mem = valid_i & w_memop & ~w_mis;

  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // gnt is the only event honoured in REQ, so an rvalid arriving with it is dropped
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_mem) w_next = REQ;
      REQ:     if (dmem_gnt_i) w_next = r_wr ? IDLE : RSP;
      RSP:     if (dmem_rvalid_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      r_addr     <= '0;
      r_type     <= BYTE;
      r_sext     <= 1'b0;
      r_we       <= 1'b0;
      r_wr       <= 1'b0;
      r_waddr    <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_wb_valid <= 1'b0;
      r_rf_we    <= 1'b0;
      r_mis      <= 1'b0;
      r_tkbr     <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_new_pc   <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_rf_we    <= 1'b0;
      r_mis      <= 1'b0;
      r_tkbr     <= 1'b0;
      case (r_state)
        IDLE: if (valid_i) begin
          if (w_start_mem) begin
            r_addr  <= w_addr;
            r_type  <= memop_type_i;
            r_sext  <= memop_sign_ext_i;
            r_we    <= rf_we_i;
            r_wr    <= memop_wr_i;
            r_waddr <= rf_waddr_i;
            r_be    <= byte_enables(memop_type_i, w_addr[1:0]);
            r_wdata <= lane_replicate(memop_type_i, rf_st_data_i);
          end else begin
            r_wb_valid <= 1'b1;
            r_rf_we    <= rf_we_i & ~w_mis;
            r_rf_waddr <= rf_waddr_i;
            r_rf_wdata <= is_jaljalr_i ? WORD_SIZE'(seq_new_pc_i) : alu_res_i;
            r_mis      <= w_mis;
            r_tkbr     <= tkbr_i;
            r_new_pc   <= new_pc_i;
          end
        end
        REQ: if (dmem_gnt_i && r_wr) begin
          r_wb_valid <= 1'b1;
          r_rf_waddr <= r_waddr;
        end
        RSP: if (dmem_rvalid_i) begin
          r_wb_valid <= 1'b1;
          r_rf_we    <= r_we;
          r_rf_waddr <= r_waddr;
          r_rf_wdata <= load_extract(dmem_rdata_i, r_addr[1:0], r_type, r_sext);
        end
        default: ;
      endcase
    end
  end

  assign stall_o      = r_state != IDLE;
  assign dmem_req_o   = r_state == REQ;
  assign dmem_we_o    = r_wr;
  assign dmem_addr_o  = {r_addr[ADDR_SIZE-1:2], 2'b00};
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;
  assign wb_valid_o   = r_wb_valid;
  assign rf_we_o      = r_rf_we;
  assign rf_waddr_o   = r_rf_waddr;
  assign rf_wdata_o   = r_rf_wdata;
  assign misaligned_o = r_mis;
  assign tkbr_o       = r_tkbr;
  assign new_pc_o     = r_new_pc;

endmodule

// File: tb/tb_segre_mem_stage.sv
// Bench for segre_mem_stage: byte-level memory reference model, a randomized memory
// responder and a writeback scoreboard fed by the instruction driver.
`timescale 1ns/1ps
module tb_segre_mem_stage;
  import segre_pkg::*;

  logic clk_i = 1'b0;
  logic rsn_i;
  logic valid_i, rf_we_i, memop_rd_i, memop_wr_i, memop_sign_ext_i, tkbr_i, is_jaljalr_i;
  logic [31:0] alu_res_i, rf_st_data_i, new_pc_i, seq_new_pc_i;
  logic [4:0] rf_waddr_i;
  memop_data_type_e memop_type_i;
  logic stall_o, dmem_req_o, dmem_we_o, wb_valid_o, rf_we_o, misaligned_o, tkbr_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, rf_wdata_o, new_pc_o;
  logic [3:0] dmem_be_o;
  logic [4:0] rf_waddr_o;
  logic dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;

  segre_mem_stage dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .valid_i(valid_i), .alu_res_i(alu_res_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_st_data_i(rf_st_data_i),
    .memop_type_i(memop_type_i), .memop_rd_i(memop_rd_i), .memop_wr_i(memop_wr_i),
    .memop_sign_ext_i(memop_sign_ext_i), .tkbr_i(tkbr_i), .new_pc_i(new_pc_i),
    .seq_new_pc_i(seq_new_pc_i), .is_jaljalr_i(is_jaljalr_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .misaligned_o(misaligned_o), .tkbr_o(tkbr_o), .new_pc_o(new_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        chk_data;
    logic        mis;
    logic        tkbr;
    logic [31:0] pc;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];
  int total = 0, bad = 0;
  logic [7:0] ref_mem[1024];
  logic [7:0] dut_mem[1024];
  int gdly_force = -1, rdly_force = -1, last_req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Writeback monitor
  wb_exp_t e;
  always @(negedge clk_i) begin
    if (!rsn_i) begin
      if (wb_valid_o) begin
        if (wb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wb: got wb_valid_o=1 required 0");
        end else begin
          e = wb_q.pop_front();
          chk("wb_rf_we", rf_we_o, e.we);
          if (e.we) chk("wb_waddr", rf_waddr_o, e.waddr);
          if (e.chk_data) chk("wb_wdata", rf_wdata_o, e.wdata);
          chk("wb_misaligned", misaligned_o, e.mis);
          chk("wb_tkbr", tkbr_o, e.tkbr);
          if (e.tkbr) chk("wb_new_pc", new_pc_o, e.pc);
        end
      end else if (tkbr_o || misaligned_o) begin
        total++; bad++;
        $display("FAIL stray_flag: got tkbr_o=%b misaligned_o=%b without wb_valid_o", tkbr_o, misaligned_o);
      end
    end
  end

  // Memory responder: random gnt/rvalid delays, ignorable rvalid noise with garbage data
  int phase = 0, gdly = 0, rdly = 0, reqc = 0;
  logic [31:0] cur_addr, cur_wd;
  logic [3:0] cur_be;
  logic cur_we;
  mem_exp_t m;
  always @(negedge clk_i) begin
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = $urandom;
    if (phase == 2) begin
      if (rdly == 0) begin
        dmem_rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) dmem_rdata_i[8*i +: 8] = dut_mem[int'(cur_addr[9:0]) + i];
        phase = 0;
      end else rdly--;
    end else begin
      if (phase == 0) begin
        if (dmem_req_o) begin
          if (mem_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: got dmem_req_o=1 addr=%h required no request", dmem_addr_o);
          end else begin
            m = mem_q.pop_front();
            chk("dmem_addr", dmem_addr_o, m.addr);
            chk("dmem_be", {28'd0, dmem_be_o}, {28'd0, m.be});
            chk("dmem_we", {31'd0, dmem_we_o}, {31'd0, m.we});
            if (m.we) chk("dmem_wdata", dmem_wdata_o, m.wdata);
          end
          cur_addr = dmem_addr_o; cur_be = dmem_be_o; cur_wd = dmem_wdata_o; cur_we = dmem_we_o;
          gdly = (gdly_force >= 0) ? gdly_force : int'($urandom_range(0, 3));
          reqc = 0;
          phase = 1;
        end else if ($urandom_range(0, 3) == 0) dmem_rvalid_i = 1'b1;
      end
      if (phase == 1) begin
        if (!dmem_req_o) phase = 0;
        else begin
          reqc++;
          if (gdly == 0) begin
            dmem_gnt_i = 1'b1;
            last_req_cycles = reqc;
            chk("dmem_stable", {dmem_addr_o[31:4] ^ cur_addr[31:4], dmem_addr_o[3:0] ^ cur_addr[3:0]}
                | {28'd0, dmem_be_o ^ cur_be} | (cur_we ? (dmem_wdata_o ^ cur_wd) : 32'd0), 32'd0);
            if ($urandom_range(0, 1) == 1) dmem_rvalid_i = 1'b1;
            if (cur_we) begin
              for (int i = 0; i < 4; i++)
                if (cur_be[i]) dut_mem[int'(cur_addr[9:0]) + i] = cur_wd[8*i +: 8];
              phase = 0;
            end else begin
              rdly = (rdly_force >= 0) ? rdly_force : int'($urandom_range(0, 2));
              phase = 2;
            end
          end else begin
            gdly--;
            if ($urandom_range(0, 1) == 1) dmem_rvalid_i = 1'b1;
          end
        end
      end
    end
  end

  // Drive one EX/MEM bundle, record its expected effects, hold it while stalled.
  task automatic issue(input logic [31:0] alu, input logic [31:0] st, input logic [4:0] wa,
                       input logic we, input logic rd, input logic wr, input memop_data_type_e t,
                       input logic sx, input logic tk, input logic jal, input logic [31:0] npc,
                       input logic [31:0] spc, output int sc);
    int sz, off, a;
    logic mis;
    longint v;
    wb_exp_t x;
    mem_exp_t mm;
    sz  = (t == BYTE) ? 1 : (t == HALF) ? 2 : 4;
    off = int'(alu[1:0]);
    a   = int'(alu[9:0]);
    mis = (rd | wr) && ((off % sz) != 0);
    x = '{we: 1'b0, waddr: wa, wdata: 32'd0, chk_data: 1'b0, mis: 1'b0, tkbr: 1'b0, pc: 32'd0};
    if ((rd | wr) && !mis) begin
      mm.addr = alu & ~32'd3;
      mm.be   = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) mm.wdata[8*i +: 8] = st[8*(i % sz) +: 8];
      mm.we = wr;
      mem_q.push_back(mm);
      if (wr) begin
        for (int i = 0; i < sz; i++) ref_mem[a + i] = st[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < sz; i++) v |= longint'(ref_mem[a + i]) << (8 * i);
        if (sx && sz < 4 && v[8*sz-1]) v -= (longint'(1) << (8 * sz));
        x.we = we; x.wdata = v[31:0]; x.chk_data = 1'b1;
      end
    end else begin
      x.we = we & ~mis;
      x.wdata = jal ? spc : alu;
      x.chk_data = 1'b1;
      x.mis = mis;
      x.tkbr = tk;
      x.pc = npc;
    end
    wb_q.push_back(x);
    valid_i = 1'b1; alu_res_i = alu; rf_st_data_i = st; rf_waddr_i = wa; rf_we_i = we;
    memop_rd_i = rd; memop_wr_i = wr; memop_type_i = t; memop_sign_ext_i = sx;
    tkbr_i = tk; is_jaljalr_i = jal; new_pc_i = npc; seq_new_pc_i = spc;
    @(posedge clk_i); #1;
    sc = 0;
    while (stall_o && sc < 50) begin
      sc++;
      @(posedge clk_i); #1;
    end
    if (sc >= 50) begin
      total++; bad++;
      $display("FAIL stall_timeout: got stall_o stuck high required release within 50 cycles");
    end
    chk("wb_latency", {31'd0, wb_valid_o}, 32'd1);
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, kind, seen;
    logic [31:0] r;
    rsn_i = 1'b1; valid_i = 1'b0; alu_res_i = '0; rf_st_data_i = '0; rf_waddr_i = '0;
    rf_we_i = 1'b0; memop_rd_i = 1'b0; memop_wr_i = 1'b0; memop_type_i = BYTE;
    memop_sign_ext_i = 1'b0; tkbr_i = 1'b0; is_jaljalr_i = 1'b0; new_pc_i = '0; seq_new_pc_i = '0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 8'($urandom);
      dut_mem[i] = ref_mem[i];
    end
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_outs", {rf_wdata_o | new_pc_o | dmem_addr_o | dmem_wdata_o},  32'd0);
    chk("rst_flags", {24'd0, rf_we_o, misaligned_o, tkbr_o, dmem_we_o, dmem_be_o}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
    rsn_i = 1'b0;
    idle(2);

    issue(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, WORD, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, sc);
    chk("alu_stall_cycles", sc, 0);
    idle(1);

    for (int i = 0; i < 4; i++) begin
      r = 32'h80FF_0000;
      ref_mem[256 + i] = r[8*i +: 8];
      dut_mem[256 + i] = r[8*i +: 8];
    end
    gdly_force = 0; rdly_force = 0;
    issue(32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, BYTE, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, sc);
    chk("lb_stall_cycles", sc, 2);
    idle(1);
    issue(32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, BYTE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, sc);
    chk("lbu_stall_cycles", sc, 2);
    idle(1);

    gdly_force = 3;
    issue(32'h202, 32'hABCD, 5'd9, 1'b1, 1'b0, 1'b1, HALF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, sc);
    chk("sh_req_cycles", last_req_cycles, 4);
    chk("sh_stall_cycles", sc, 4);
    gdly_force = -1; rdly_force = -1;
    idle(1);

    issue(32'h101, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, WORD, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, sc);
    chk("lw_mis_stall_cycles", sc, 0);
    idle(1);

    issue(32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, WORD, 1'b0, 1'b1, 1'b1, 32'h400, 32'h84, sc);
    idle(2);

    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 2)
        issue($urandom, 32'h0, 5'($urandom), 1'($urandom), 1'b0, 1'b0, WORD, 1'b0, 1'b0, 1'b0,
              32'h0, 32'h0, sc);
      else if (kind == 3)
        issue($urandom, 32'h0, 5'($urandom), 1'($urandom), 1'b0, 1'b0, WORD, 1'b0, 1'($urandom),
              1'($urandom), $urandom, $urandom, sc);
      else
        issue(32'($urandom_range(0, 1019)), $urandom, 5'($urandom), 1'($urandom), kind <= 6,
              kind > 6, memop_data_type_e'($urandom_range(0, 2)), 1'($urandom), 1'b0, 1'b0,
              32'h0, 32'h0, sc);
      idle(int'($urandom_range(0, 2)));
    end

    // Reset while a load waits for its response; the late rvalid must be dropped.
    gdly_force = 0; rdly_force = 5;
    mem_q.push_back('{addr: 32'h100, be: 4'b1111, wdata: 32'h0, we: 1'b0});
    valid_i = 1'b1; alu_res_i = 32'h100; rf_we_i = 1'b1; rf_waddr_i = 5'd4;
    memop_rd_i = 1'b1; memop_wr_i = 1'b0; memop_type_i = WORD; tkbr_i = 1'b0; is_jaljalr_i = 1'b0;
    @(posedge clk_i); #1;
    valid_i = 1'b0; memop_rd_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rsp_stall", {31'd0, stall_o}, 32'd1);
    #2 rsn_i = 1'b1;
    #1;
    chk("async_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("async_rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("async_rst_outs", {27'd0, wb_valid_o, rf_we_o, dmem_we_o, misaligned_o, tkbr_o}
        | dmem_addr_o | rf_wdata_o, 32'd0);
    @(posedge clk_i); #1;
    rsn_i = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk_i); #1;
      if (wb_valid_o || stall_o) seen++;
    end
    chk("post_rst_quiet", seen, 0);
    gdly_force = -1; rdly_force = -1;

    issue(32'hCAFE, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, WORD, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, sc);
    idle(3);
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("mem_queue_drained", mem_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
